// File: rtl/result_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : result_decoder_if
// Description : Upstream/downstream handshake bundle for result_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_decoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_cntrl;
    logic [3:0]       in_data;
    logic             in_parity;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_fcode;
    logic [3:0]       out_data;
    logic             out_perr;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_cntrl, in_data, in_parity, out_ready,
        input  in_ready, out_valid, out_fcode, out_data, out_perr, err_count
    );

    modport slave (
        input  in_valid, in_cntrl, in_data, in_parity, out_ready,
        output in_ready, out_valid, out_fcode, out_data, out_perr, err_count
    );
endinterface
`default_nettype wire

// File: rtl/result_decoder.sv
`default_nettype none
// ============================================================================
// Module      : result_decoder
// Description : Parity-checking FIFO of ALU results with one-hot control
//               decode at the head. Macro PARITY_ERR_CNT_EN adds a
//               saturating parity-error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module result_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    result_decoder_if.slave  bus
);
    localparam int c_AW = $clog2(DEPTH);

    logic [2:0]  r_cntrl_mem [DEPTH];
    logic [3:0]  r_data_mem  [DEPTH];
    logic        r_perr_mem  [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_perr_in;

    // Extra pointer bit separates full (MSBs differ) from empty (equal).
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push    = bus.in_valid && !w_full;
    assign w_pop     = !w_empty && bus.out_ready;
    assign w_perr_in = ~(^{bus.in_data, bus.in_parity});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_cntrl_mem[r_wr_ptr[c_AW-1:0]] <= bus.in_cntrl;
            r_data_mem[r_wr_ptr[c_AW-1:0]]  <= bus.in_data;
            r_perr_mem[r_wr_ptr[c_AW-1:0]]  <= w_perr_in;
        end
    end

    logic [2:0] w_head_cntrl;
    logic [3:0] w_head_data;
    logic       w_head_perr;

    assign w_head_cntrl = r_cntrl_mem[r_rd_ptr[c_AW-1:0]];
    assign w_head_data  = r_data_mem[r_rd_ptr[c_AW-1:0]];
    assign w_head_perr  = r_perr_mem[r_rd_ptr[c_AW-1:0]];

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;

    // Head fields are forced to zero whenever nothing is buffered.
    always_comb begin
        bus.out_fcode = 8'h00;
        bus.out_data  = 4'h0;
        bus.out_perr  = 1'b0;
        if (!w_empty) begin
            bus.out_fcode = 8'h01 << w_head_cntrl;
            bus.out_data  = w_head_data;
            bus.out_perr  = w_head_perr;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (w_push && w_perr_in && !(&r_err_count)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_decoder
// Description : Directed self-checking bench for result_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_decoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   exp_err;

    result_decoder_if #(.CNT_W(CNT_W)) bus ();

    result_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic good_par(input logic [3:0] d);
        return ~(^d);
    endfunction

    // Model of the error counter; stays 0 when the counter is not built.
    task automatic model_push(input logic [3:0] d, input logic p);
`ifdef PARITY_ERR_CNT_EN
        if ((^{d, p}) == 1'b0 && exp_err != 255) exp_err = exp_err + 1;
`endif
    endtask

    // Present one word for exactly one rising edge, then drop in_valid.
    task automatic push_one(input logic [2:0] c, input logic [3:0] d, input logic p);
        bus.in_valid  = 1'b1;
        bus.in_cntrl  = c;
        bus.in_data   = d;
        bus.in_parity = p;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        model_push(d, p);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_err  = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_cntrl  = 3'd0;
        bus.in_data   = 4'h0;
        bus.in_parity = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_fcode",     {24'd0, bus.out_fcode}, 32'd0);
        check_val("rst_data",      {28'd0, bus.out_data},  32'd0);
        check_val("rst_perr",      {31'd0, bus.out_perr},  32'd0);
        check_val("rst_err",       {24'd0, bus.err_count}, 32'd0);
        reset = 1'b1;
        #3;

        // First push on first edge after release, good parity.
        bus.out_ready = 1'b1;
        push_one(3'd4, 4'b0010, 1'b0);
        check_val("p1_valid", {31'd0, bus.out_valid}, 32'd1);
        check_val("p1_fcode", {24'd0, bus.out_fcode}, 32'h10);
        check_val("p1_data",  {28'd0, bus.out_data},  32'h2);
        check_val("p1_perr",  {31'd0, bus.out_perr},  32'd0);
        check_val("p1_err",   {24'd0, bus.err_count}, 32'd0);

        // Bad parity word.
        push_one(3'd0, 4'b0010, 1'b1);
        check_val("p2_fcode", {24'd0, bus.out_fcode}, 32'h01);
        check_val("p2_perr",  {31'd0, bus.out_perr},  32'd1);
        check_val("p2_err",   {24'd0, bus.err_count}, exp_err);

        // One-hot decode over all control values.
        for (int c = 0; c < 8; c++) begin
            logic [3:0] d;
            d = 4'(c + 3);
            push_one(3'(c), d, good_par(d));
            check_val("fcode_sweep", {24'd0, bus.out_fcode}, 32'd1 << c);
            check_val("data_sweep",  {28'd0, bus.out_data},  {28'd0, d});
        end
        @(posedge clk);
        #1;
        check_val("drain_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("drain_fcode", {24'd0, bus.out_fcode}, 32'd0);

        // Fill to DEPTH with downstream stalled.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            push_one(3'(i), 4'(i), good_par(4'(i)));
        end
        check_val("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid  = 1'b1;
        bus.in_cntrl  = 3'd5;
        bus.in_data   = 4'h5;
        bus.in_parity = good_par(4'h5);
        @(posedge clk);
        #1;
        check_val("full_head",  {28'd0, bus.out_data}, 32'h1);
        check_val("full_block", {31'd0, bus.in_ready}, 32'd0);

        // Push attempt and pop together on a full buffer: only the pop lands.
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_val("pp_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 2; i <= DEPTH; i++) begin
            check_val("order_data",  {28'd0, bus.out_data},  32'(i));
            check_val("order_fcode", {24'd0, bus.out_fcode}, 32'd1 << i);
            @(posedge clk);
            #1;
        end
        check_val("no_fifth", {31'd0, bus.out_valid}, 32'd0);

        // Saturation: 255 bad pushes, then one more.
        for (int i = 0; i < 255; i++) push_one(3'd1, 4'h0, 1'b0);
        check_val("sat_255", {24'd0, bus.err_count}, exp_err);
        push_one(3'd1, 4'h0, 1'b0);
        check_val("sat_hold", {24'd0, bus.err_count}, exp_err);
`ifdef PARITY_ERR_CNT_EN
        check_val("sat_value", {24'd0, bus.err_count}, 32'd255);
`endif
        @(posedge clk);
        #1;

        // Asynchronous reset with three words buffered.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(3'd2, 4'(i + 9), good_par(4'(i + 9)));
        check_val("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("arst_ready", {31'd0, bus.in_ready},  32'd1);
        check_val("arst_err",   {24'd0, bus.err_count}, 32'd0);
        check_val("arst_data",  {28'd0, bus.out_data},  32'd0);
        #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/result_decoder.md
RESULT_DECODER -- requirements
Module: result_decoder

Interface
REQ-001 Parameter DEPTH, default 4, buffer entry count; power of two, >= 2.
REQ-002 Parameter CNT_W, default 8, parity-error counter width.
REQ-003 clk  input  1  Single clock; all state changes on rising edge.
REQ-004 reset  input  1  Asynchronous, active-low reset.
REQ-005 in_valid  input  1  Upstream word present.
REQ-006 in_ready  output  1  Block can accept a word this cycle.
REQ-007 in_cntrl  input  3  Encoded ALU control from the pipeline encoder.
REQ-008 in_data  input  4  ALU result.
REQ-009 in_parity  input  1  Parity bit produced upstream, defined as NOT(XOR of in_data).
REQ-010 out_valid  output  1  Buffered word available at head.
REQ-011 out_ready  input  1  Downstream consumes head word this cycle.
REQ-012 out_fcode  output  8  One-hot decode of head cntrl.
REQ-013 out_data  output  4  Head data.
REQ-014 out_perr  output  1  Head word failed parity check.
REQ-015 err_count  output  CNT_W  Saturating count of accepted words with parity error.

Function
REQ-016 Push occurs on an edge where in_valid and in_ready are both 1; pop occurs where out_valid and out_ready are both 1.
REQ-017 in_ready is 1 iff occupancy < DEPTH; no combinational path from out_ready to in_ready, so a full buffer blocks a push even when a pop occurs in the same cycle.
REQ-018 out_valid is 1 iff occupancy > 0; out_* are driven from registered buffer storage only, with no input-to-output combinational path.
REQ-019 Latency: a word pushed at edge N is visible on out_* with out_valid=1 after edge N, provided it is at the head.
REQ-020 Order is FIFO; a simultaneous push and pop with 0 < occupancy < DEPTH leaves occupancy unchanged.
REQ-021 A push on an empty buffer with out_ready=1 does not pop that same word in the same cycle.
REQ-022 Read and write pointers wrap modulo DEPTH; occupancy is tracked with a pointer extra bit or counter to distinguish full from empty.
REQ-023 out_fcode has exactly bit[cntrl] set, for all 8 cntrl values.
REQ-024 The parity check is computed at push time: perr = 1 iff XOR(in_data, in_parity) == 0; the stored flag travels with the word.
REQ-025 Every push with perr=1 increments err_count by 1; at all-ones it holds (saturates) and does not wrap.
REQ-026 When out_valid=0, out_fcode, out_data, and out_perr are all 0.

Reset
REQ-027 While reset=0, occupancy and pointers are 0, in_ready=1, out_valid=0, out_fcode=0, out_data=0, out_perr=0, and err_count=0.
REQ-028 A reset asserted mid-operation discards all buffered words immediately, without waiting for a clock edge.
REQ-029 The first push is possible on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro PARITY_ERR_CNT_EN: when defined, the err_count counter is implemented per REQ-025.
REQ-031 When PARITY_ERR_CNT_EN is not defined, err_count is a constant 0, no counter register exists, and out_perr still functions.

Verification
REQ-032 Push cntrl=4, data=0010, parity=0, out_ready=1 -> next cycle out_fcode=00010000, out_data=0010, out_perr=0, err_count=0.
REQ-033 Push cntrl=0, data=0010, parity=1 -> out_fcode=00000001, out_perr=1, err_count=1 (0 without the macro).
REQ-034 out_ready=0; push 4 words (DEPTH=4) -> in_ready=0 after the 4th; a 5th in_valid is not accepted; releasing out_ready returns all 4 in order, and in_ready=1 after the first pop.
REQ-035 Full buffer, in_valid=1 and out_ready=1 in the same cycle -> one pop, no push; occupancy becomes 3.
REQ-036 Preload err_count to 255 via 255 bad pushes, then one more bad push -> err_count stays 255.
REQ-037 3 words buffered, pulse reset low between edges -> out_valid=0, in_ready=1, and err_count=0 immediately; no stale words appear after release.
